// File: rtl/mac_coproc_pkg.sv
// rtl/mac_coproc_pkg.sv - shared command encoding and stage payload for the MAC coprocessor
package mac_coproc_pkg;

   typedef enum logic [2:0] {
      MAC_NOP = 3'd0,
      MAC_MUL = 3'd1,
      MAC_MAC = 3'd2,
      MAC_CLR = 3'd3,
      MAC_RDL = 3'd4,
      MAC_RDH = 3'd5
   } mac_cmd_t;

   // Payload fields are sized for the widest supported configuration;
   // narrower lane indices are zero-extended, narrower products sign-extended.
   localparam int MAC_LANE_W = 8;
   localparam int MAC_PROD_W = 64;

   typedef struct packed {
      mac_cmd_t                       op;
      logic [MAC_LANE_W-1:0]          lane;
      logic [4:0]                     rd;
      logic signed [MAC_PROD_W-1:0]   product;
   } mac_stage_t;

   function automatic logic is_read(input mac_cmd_t op);
      return (op == MAC_RDL) || (op == MAC_RDH);
   endfunction

endpackage

// File: rtl/mac_cmd_fifo.sv
// rtl/mac_cmd_fifo.sv - synchronous command queue with full/empty/count
module mac_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array: data only, pointers qualify validity so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_coproc.sv
// rtl/mac_coproc.sv - queued multi-lane multiply-accumulate coprocessor
module mac_coproc
   import mac_coproc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int LANES      = 4,
   parameter int ACC_W      = 64,
   parameter int MUL_STAGES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  mac_cmd_t                   cmd_op,
   input  logic [$clog2(LANES)-1:0]   cmd_lane,
   input  logic [XLEN-1:0]            cmd_a,
   input  logic [XLEN-1:0]            cmd_b,
   input  logic [4:0]                 cmd_rd,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [XLEN-1:0]            rsp_data,
   output logic [4:0]                 rsp_rd,
   output logic                       busy,
   output logic [LANES-1:0]           ovf
);

   localparam int LW    = $clog2(LANES);
   localparam int CMD_W = 3 + LW + 5 + 2 * XLEN;

   if (LANES < 2 || (LANES & (LANES - 1)) != 0 || LANES > (1 << MAC_LANE_W)) begin : g_bad_lanes
      $error("LANES must be a power of two, at least 2, within the payload lane field");
   end
   if (ACC_W < 2 * XLEN) begin : g_bad_acc
      $error("ACC_W must be at least 2*XLEN");
   end
   if (2 * XLEN > MAC_PROD_W) begin : g_bad_xlen
      $error("XLEN exceeds the payload product field");
   end
   if (MUL_STAGES < 1) begin : g_bad_stages
      $error("MUL_STAGES must be at least 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end

   logic [CMD_W-1:0]               fifo_dout;
   logic                           fifo_full;
   logic                           fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]    fifo_count;
   logic                           advance;
   logic                           commit;

   mac_cmd_t                       head_op;
   logic [LW-1:0]                  head_lane;
   logic [4:0]                     head_rd;
   logic [XLEN-1:0]                head_a;
   logic [XLEN-1:0]                head_b;
   logic signed [2*XLEN-1:0]       head_prod;
   mac_stage_t                     head_stage;

   mac_stage_t                     stg [MUL_STAGES];
   logic [MUL_STAGES-1:0]          stg_valid;
   mac_stage_t                     tail;

   logic [ACC_W-1:0]               acc [LANES];
   logic [ACC_W-1:0]               acc_sel;
   logic [ACC_W-1:0]               prod_ext;
   logic [ACC_W-1:0]               acc_sum;
   logic                           mac_ovf;

   // A held response that is not being taken freezes the pipe and the queue head.
   assign advance   = !rsp_valid || rsp_ready;
   assign commit    = advance && stg_valid[MUL_STAGES-1];
   assign cmd_ready = rst && !fifo_full;
   assign busy      = (fifo_count != '0) || (|stg_valid) || rsp_valid;

   mac_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .din   ({cmd_op, cmd_lane, cmd_rd, cmd_a, cmd_b}),
      .pop   (advance),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_op   = mac_cmd_t'(fifo_dout[CMD_W-1 -: 3]);
   assign head_lane = fifo_dout[CMD_W-4 -: LW];
   assign head_rd   = fifo_dout[2*XLEN+4 -: 5];
   assign head_a    = fifo_dout[2*XLEN-1 -: XLEN];
   assign head_b    = fifo_dout[XLEN-1:0];
   assign head_prod = (2*XLEN)'($signed(head_a)) * (2*XLEN)'($signed(head_b));

   assign head_stage.op      = head_op;
   assign head_stage.lane    = MAC_LANE_W'(head_lane);
   assign head_stage.rd      = head_rd;
   assign head_stage.product = MAC_PROD_W'(head_prod);

   assign tail = stg[MUL_STAGES-1];

   // Stage valids: the queue head enters stage 1 whenever the pipe advances.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_valid <= '0;
      end else if (advance) begin
         stg_valid[0] <= !fifo_empty;
         for (int i = 1; i < MUL_STAGES; i++) begin
            stg_valid[i] <= stg_valid[i-1];
         end
      end
   end

   // Stage payloads: product is formed entering stage 1 and carried to commit.
   always_ff @(posedge clk) begin
      if (advance) begin
         stg[0] <= head_stage;
         for (int i = 1; i < MUL_STAGES; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   // Commit datapath: select the target accumulator and form the wrapped sum.
   always_comb begin
      acc_sel = '0;
      for (int i = 0; i < LANES; i++) begin
         if (tail.lane == MAC_LANE_W'(i)) begin
            acc_sel = acc[i];
         end
      end
      prod_ext = ACC_W'($signed(tail.product));
      acc_sum  = acc_sel + prod_ext;
      mac_ovf  = (acc_sel[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_sel[ACC_W-1]);
   end

   // Accumulators and sticky overflow flags update on the commit edge only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) begin
            acc[i] <= '0;
         end
         ovf <= '0;
      end else if (commit) begin
         for (int i = 0; i < LANES; i++) begin
            if (tail.lane == MAC_LANE_W'(i)) begin
               case (tail.op)
                  MAC_MUL: acc[i] <= prod_ext;
                  MAC_MAC: begin
                     acc[i] <= acc_sum;
                     if (mac_ovf) begin
                        ovf[i] <= 1'b1;
                     end
                  end
                  MAC_CLR: begin
                     acc[i] <= '0;
                     ovf[i] <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Response register: a read commit may reload it on the same edge it retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_rd    <= '0;
      end else if (commit && is_read(tail.op)) begin
         rsp_valid <= 1'b1;
         rsp_data  <= (tail.op == MAC_RDL) ? acc_sel[XLEN-1:0] : acc_sel[2*XLEN-1:XLEN];
         rsp_rd    <= tail.rd;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_coproc.sv
// tb/tb_mac_coproc.sv - directed self-checking bench for mac_coproc
module tb_mac_coproc;
   import mac_coproc_pkg::*;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   mac_cmd_t    cmd_op;
   logic [1:0]  cmd_lane;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [4:0]  cmd_rd;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        busy;
   logic [3:0]  ovf;

   int errors = 0;
   int checks = 0;
   logic [36:0] rsp_q [$];

   mac_coproc dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_lane  (cmd_lane),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_rd    (cmd_rd),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_rd    (rsp_rd),
      .busy      (busy),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every completed response handshake, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) rsp_q.push_back({rsp_rd, rsp_data});
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input mac_cmd_t op, input int lane, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int n;
      n = 0;
      cmd_op = op; cmd_lane = 2'(lane); cmd_a = a; cmd_b = b; cmd_rd = rd; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_accept got=%b want=1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic do_read(input mac_cmd_t op, input int lane, input logic [4:0] tag,
                          output logic [31:0] d, output logic [4:0] r, output int n);
      rsp_q.delete();
      issue(op, lane, 32'd0, 32'd0, tag);
      wait_idle();
      n = rsp_q.size();
      d = 32'hDEADBEEF;
      r = 5'd0;
      if (n > 0) {r, d} = rsp_q[0];
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = MAC_NOP; cmd_lane = 2'd0;
      cmd_a = '0; cmd_b = '0; cmd_rd = '0; rsp_ready = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got=ready%b busy%b valid%b want=000", cmd_ready, busy, rsp_valid);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || ovf !== 4'h0 || rsp_data !== 32'h0 || rsp_rd !== 5'h0) begin
         errors++;
         $display("FAIL reset_release got=ready%b ovf%h data%h rd%h want=1 0 0 0", cmd_ready, ovf, rsp_data, rsp_rd);
      end
   endtask

   task automatic test_mul_read();
      logic [31:0] d; logic [4:0] r; int n;
      issue(MAC_MUL, 0, 32'd3, 32'hFFFFFFFB, 5'd0);
      cmd_op = MAC_RDL; cmd_lane = 2'd0; cmd_rd = 5'd7; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rdl_latency_early got=%b want=0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFFFF1 || rsp_rd !== 5'd7) begin
         errors++;
         $display("FAIL rdl_signed got=v%b %h rd%0d want=v1 fffffff1 rd7", rsp_valid, rsp_data, rsp_rd);
      end
      tick();
      do_read(MAC_RDH, 0, 5'd8, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'hFFFFFFFF || r !== 5'd8) begin
         errors++;
         $display("FAIL rdh_signed got=n%0d %h rd%0d want=n1 ffffffff rd8", n, d, r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [4:0] r; int n;
      issue(MAC_MUL, 1, 32'h10000, 32'h10000, 5'd0);
      issue(MAC_MAC, 1, 32'h10000, 32'h10000, 5'd0);
      do_read(MAC_RDL, 1, 5'd2, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h0) begin
         errors++;
         $display("FAIL b2b_rdl got=n%0d %h want=n1 00000000", n, d);
      end
      do_read(MAC_RDH, 1, 5'd3, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h2) begin
         errors++;
         $display("FAIL b2b_rdh got=n%0d %h want=n1 00000002", n, d);
      end
      do_read(MAC_RDL, 2, 5'd4, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h0) begin
         errors++;
         $display("FAIL other_lane2 got=n%0d %h want=n1 00000000", n, d);
      end
      do_read(MAC_RDH, 3, 5'd5, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h0) begin
         errors++;
         $display("FAIL other_lane3 got=n%0d %h want=n1 00000000", n, d);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic [4:0] r; int n;
      issue(MAC_MUL, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      issue(MAC_MAC, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      wait_idle();
      checks++;
      if (ovf !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_one_mac got=%b want=0000", ovf);
      end
      issue(MAC_MAC, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      wait_idle();
      checks++;
      if (ovf !== 4'b0100) begin
         errors++;
         $display("FAIL ovf_set got=%b want=0100", ovf);
      end
      do_read(MAC_RDH, 2, 5'd6, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'hBFFFFFFD) begin
         errors++;
         $display("FAIL ovf_wrap_hi got=n%0d %h want=n1 bffffffd", n, d);
      end
      do_read(MAC_RDL, 2, 5'd6, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h00000003) begin
         errors++;
         $display("FAIL ovf_wrap_lo got=n%0d %h want=n1 00000003", n, d);
      end
      issue(MAC_MUL, 2, 32'd1, 32'd1, 5'd0);
      wait_idle();
      checks++;
      if (ovf !== 4'b0100) begin
         errors++;
         $display("FAIL ovf_sticky got=%b want=0100", ovf);
      end
      issue(MAC_CLR, 2, 32'd0, 32'd0, 5'd0);
      wait_idle();
      checks++;
      if (ovf !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_clr got=%b want=0000", ovf);
      end
      do_read(MAC_RDL, 2, 5'd9, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'h0) begin
         errors++;
         $display("FAIL clr_read got=n%0d %h want=n1 00000000", n, d);
      end
   endtask

   task automatic test_backpressure();
      int accepted;
      int tag;
      rsp_ready = 1'b0;
      accepted = 0;
      tag = 1;
      cmd_op = MAC_RDL; cmd_lane = 2'd0; cmd_a = '0; cmd_b = '0;
      for (int c = 0; c < 8; c++) begin
         cmd_rd = 5'(tag);
         cmd_valid = 1'b1;
         if (cmd_ready) begin
            accepted++;
            tag++;
         end
         tick();
      end
      checks++;
      if (accepted !== 7 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_capacity got=acc%0d ready%b want=acc7 ready0", accepted, cmd_ready);
      end
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rd !== 5'd1 || rsp_data !== 32'hFFFFFFF1) begin
         errors++;
         $display("FAIL bp_hold got=v%b rd%0d %h want=v1 rd1 fffffff1", rsp_valid, rsp_rd, rsp_data);
      end
      repeat (3) tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rd !== 5'd1 || rsp_data !== 32'hFFFFFFF1) begin
         errors++;
         $display("FAIL bp_stable got=v%b rd%0d %h want=v1 rd1 fffffff1", rsp_valid, rsp_rd, rsp_data);
      end
      rsp_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rd !== 5'(k)) begin
            errors++;
            $display("FAIL bp_drain got=v%b rd%0d want=v1 rd%0d", rsp_valid, rsp_rd, k);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle got=busy%b v%b want=busy0 v0", busy, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [4:0] r; int n;
      issue(MAC_MUL, 3, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      issue(MAC_MAC, 3, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      issue(MAC_MAC, 3, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
      wait_idle();
      checks++;
      if (ovf !== 4'b1000) begin
         errors++;
         $display("FAIL pre_reset_ovf got=%b want=1000", ovf);
      end
      issue(MAC_RDL, 3, 32'd0, 32'd0, 5'd20);
      issue(MAC_RDL, 3, 32'd0, 32'd0, 5'd21);
      issue(MAC_RDL, 3, 32'd0, 32'd0, 5'd22);
      rst = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || ovf !== 4'h0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got=v%b busy%b ovf%b ready%b want=0 0 0000 0", rsp_valid, busy, ovf, cmd_ready);
      end
      repeat (2) tick();
      rst = 1'b1;
      rsp_q.delete();
      repeat (10) tick();
      checks++;
      if (rsp_q.size() !== 0) begin
         errors++;
         $display("FAIL post_reset_quiet got=%0d want=0", rsp_q.size());
      end
      for (int l = 0; l < 4; l++) begin
         do_read(MAC_RDL, l, 5'(l), d, r, n);
         checks++;
         if (n !== 1 || d !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_lane%0d got=n%0d %h want=n1 00000000", l, n, d);
         end
      end
   endtask

   task automatic test_nop_interleave();
      logic [31:0] d; logic [4:0] r; int n;
      issue(MAC_MUL, 1, 32'd5, 32'd7, 5'd0);
      wait_idle();
      rsp_q.delete();
      issue(MAC_NOP, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd30);
      issue(MAC_RDL, 1, 32'd0, 32'd0, 5'd10);
      issue(MAC_NOP, 0, 32'd9, 32'd9, 5'd31);
      issue(MAC_NOP, 1, 32'd9, 32'd9, 5'd31);
      issue(MAC_RDL, 0, 32'd0, 32'd0, 5'd11);
      issue(MAC_NOP, 1, 32'd1, 32'd1, 5'd31);
      issue(MAC_RDH, 1, 32'd0, 32'd0, 5'd12);
      wait_idle();
      checks++;
      if (rsp_q.size() !== 3) begin
         errors++;
         $display("FAIL nop_count got=%0d want=3", rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0] !== {5'd10, 32'd35} || rsp_q[1] !== {5'd11, 32'd0} || rsp_q[2] !== {5'd12, 32'd0}) begin
            errors++;
            $display("FAIL nop_order got=%h %h %h want=%h %h %h", rsp_q[0], rsp_q[1], rsp_q[2],
                     {5'd10, 32'd35}, {5'd11, 32'd0}, {5'd12, 32'd0});
         end
      end
      do_read(MAC_RDL, 1, 5'd13, d, r, n);
      checks++;
      if (n !== 1 || d !== 32'd35 || r !== 5'd13) begin
         errors++;
         $display("FAIL nop_unchanged got=n%0d %h rd%0d want=n1 00000023 rd13", n, d, r);
      end
   endtask

   initial begin
      test_reset();
      test_mul_read();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_nop_interleave();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_coproc.md
# mac_coproc

Parametrised multi-lane multiply-accumulate coprocessor for the pipelined RV32I core. It replaces the single fixed MAC path with the following:
- a queued command interface and `LANES` independent accumulators;
- a configurable-depth multiplier pipeline;
- valid/ready back-pressure on responses;
- sticky per-lane overflow flags.

It sits beside the execute/memory stages. The core issues commands, and `busy` feeds the hazard unit as a stall source.

## Interface
Parameters:
- `XLEN`, 32, operand and response width
- `LANES`, 4, accumulator count; power of two, ≥2
- `ACC_W`, 64, accumulator width; ≥2·XLEN
- `MUL_STAGES`, 2, multiplier pipeline registers; ≥1
- `FIFO_DEPTH`, 4, command queue entries; power of two, ≥2

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: queue can accept.
- `cmd_op` in `mac_cmd_t`: operation.
- `cmd_lane` in `$clog2(LANES)`: target accumulator.
- `cmd_a`, `cmd_b` in XLEN: signed operands.
- `cmd_rd` in 5: destination tag, echoed on the response.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out XLEN: read result.
- `rsp_rd` out 5: echoed tag.
- `busy` out 1: any command queued, in flight, or response pending.
- `ovf` out LANES: sticky signed-overflow flag per lane.

## Operation
- Command acceptance:
  - A command is accepted on an edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. There is no same-cycle pop bypass, so `cmd_ready` stays low at full even when a pop occurs that cycle.
- Issue:
  - The FIFO head pops into stage 1 when stage 1 is free or advancing.
  - Ops flow in order, one per cycle, through `MUL_STAGES` registers. The signed XLEN×XLEN product is formed in these stages.
  - The final (commit) edge applies the op:
    - MAC_NOP: no effect, no response.
    - MAC_MUL: acc[lane] = sext(product).
    - MAC_MAC: acc[lane] = acc[lane] + sext(product), wrapping modulo 2^ACC_W. If the operand signs match and the result sign differs, set `ovf[lane]`.
    - MAC_CLR: acc[lane] = 0 and `ovf[lane]` = 0.
    - MAC_RDL / MAC_RDH: load the response register with acc[lane][XLEN-1:0] / acc[lane][2·XLEN-1:XLEN], load `rsp_rd` with the tag, and set `rsp_valid`.
- Read ordering: RD ops read the accumulator at commit, so they always observe every earlier command to any lane. No bypass is needed, because commits are in order and one per cycle.
- Back-pressure:
  - While `rsp_valid && !rsp_ready`, the pipeline and FIFO pop freeze completely.
  - `rsp_data`/`rsp_rd` hold stable and the FIFO may still accept until full.
- Response handshake: on `rsp_valid && rsp_ready`, the response retires. That same edge may load the next response, giving full throughput.
- `busy` = FIFO non-empty | any stage valid | `rsp_valid`.
- Reset (asynchronous, `rst` low) clears:
  - FIFO pointers and count;
  - all stage valids;
  - all accumulators, `ovf`, `rsp_valid`, `rsp_data`, and `rsp_rd` (to 0);
  - `busy` to 0.
- `cmd_ready` is 0 while `rst` is low and 1 after release. In-flight commands are discarded.

## Timing
- Latency: a command accepted at edge E0 commits at edge E0+MUL_STAGES+1 when the pipeline is empty and unstalled. `rsp_valid` is high after that edge (3 cycles at default).
- Throughput: one command per cycle sustained.
- Storage with `rsp_ready` low: holds FIFO_DEPTH + MUL_STAGES + 1 commands before `cmd_ready` drops.
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Structure
- The `types` package holds:
  - `mac_cmd_t` enum (3 bits): MAC_NOP=0, MAC_MUL, MAC_MAC, MAC_CLR, MAC_RDL, MAC_RDH;
  - stage payload struct `mac_stage_t` (op, lane, rd, product).
- Sub-module `mac_cmd_fifo`: parametrised synchronous FIFO (width, depth) with full/empty/count.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
All scenarios use default parameters.
- **Signed multiply and read-back:** after reset, MUL lane0 a=3 b=−5, then RDL lane0 rd=7 → `rsp_data`=0xFFFFFFF1 and `rsp_rd`=7, 3 cycles after RDL acceptance. A following RDH returns 0xFFFFFFFF.
- **Back-to-back accumulate:** MUL lane1 0x10000×0x10000, then MAC same, issued back-to-back → RDL=0x00000000, RDH=0x00000002. Other lanes read 0.
- **Overflow and clear:**
  - MUL lane2 0x7FFFFFFF×0x7FFFFFFF, then MAC ×2 → `ovf[2]`=1 and stays 1.
  - CLR lane2 → `ovf[2]`=0 and RDL returns 0.
- **Back-pressure:**
  - With `rsp_ready`=0, offer 8 back-to-back RDLs (tags 1..8) → exactly 7 accepted, then `cmd_ready`=0, with `rsp_data`/`rsp_rd`=1 stable.
  - Raise `rsp_ready` → tags 1..7 are delivered one per cycle, and `busy` falls after the last.
- **Reset mid-operation:** drive `rst` low with 3 commands in flight → `rsp_valid`, `busy`, and `ovf` are 0 immediately. After release there are no responses, and RDL on all lanes returns 0.
- **NOP interleave:** MAC_NOP interleaved with RDs → no response for the NOPs, RD responses in order, accumulators unchanged.
